// File: rtl/vec_dispatch.sv
// vec_dispatch: FIFO-buffered vector feeder for the sum stage; clears it, holds a vector
// for HOLD_CYC cycles, then offers the captured result with a valid/ready handshake.
module vec_dispatch #(
  parameter int DATA_W = 16,
  parameter int POS_W = 4,
  parameter int DEPTH = 4,
  parameter int HOLD_CYC = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic [DATA_W-1:0] vec_data,
  output logic vec_clr,
  input  logic [POS_W-1:0] sum_in,
  output logic [POS_W-1:0] out_sum,
  output logic out_valid,
  input  logic out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count, count_nxt;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign push = in_valid && in_ready;
  // the head is popped exactly when the FSM enters CLEAR
  assign pop = count != '0 && (state == IDLE || (state == DONE && out_ready));
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= in_data;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      cnt <= '0;
      in_ready <= 1'b1;
      vec_data <= '0;
      vec_clr <= 1'b1;
      out_sum <= '0;
      out_valid <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count_nxt;
      in_ready <= count_nxt != CNT_FULL;
      if (pop) vec_data <= mem[rptr];
      case (state)
        IDLE: if (pop) state <= CLEAR;
        CLEAR: begin
          state <= RUN;
          vec_clr <= 1'b0;
          cnt <= '0;
        end
        RUN: if (cnt == CW'(HOLD_CYC - 1)) begin
          state <= DONE;
          vec_clr <= 1'b1;
          out_sum <= sum_in;
          out_valid <= 1'b1;
        end else cnt <= cnt + CW'(1);
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= pop ? CLEAR : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_dispatch.sv
// tb_vec_dispatch: directed and randomized checks of vec_dispatch against a timestamp-based model.
module tb_vec_dispatch;
  localparam int H = 3;
  localparam int DEPTH = 4;
  logic clock = 0;
  logic reset = 0;
  logic [15:0] in_data = '0;
  logic in_valid = 0;
  logic in_ready;
  logic [15:0] vec_data;
  logic vec_clr;
  logic [3:0] sum_in;
  logic [3:0] out_sum;
  logic out_valid;
  logic out_ready = 1;
  int tests = 0;
  int fails = 0;
  vec_dispatch #(.DATA_W(16), .POS_W(4), .DEPTH(DEPTH), .HOLD_CYC(H)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vec_data(vec_data), .vec_clr(vec_clr), .sum_in(sum_in), .out_sum(out_sum),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clock = ~clock;
  // sum stage stand-in: bit count of the presented vector while its clear is low
  assign sum_in = vec_clr ? 4'h0 : 4'($countones(vec_data));
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [15:0] q[$];
  logic busy = 0;
  int t_clr = 0;
  int cyc = 0;
  logic [15:0] cur = '0;
  logic [3:0] msum = '0;
  // a job cleared at cycle t_clr runs in t_clr+1..t_clr+H and is done from t_clr+H+1
  function automatic logic in_run();
    return busy && cyc > t_clr && cyc <= t_clr + H;
  endfunction
  function automatic logic in_done();
    return busy && cyc > t_clr + H;
  endfunction
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      busy = 0;
      cur = '0;
      msum = '0;
      cyc = 0;
      t_clr = 0;
    end else begin
      logic full, done, start;
      full = q.size() == DEPTH;
      done = in_done();
      start = q.size() != 0 && (!busy || (done && out_ready));
      if (busy && cyc == t_clr + H) msum = 4'($countones(cur));
      if (done && out_ready) busy = 0;
      if (start) begin
        cur = q.pop_front();
        busy = 1;
        t_clr = cyc + 1;
      end
      if (in_valid && !full) q.push_back(in_data);
      cyc++;
    end
  end
  always @(negedge clock) begin
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("vec_clr", vec_clr, !in_run());
    chk("out_valid", out_valid, in_done());
    chk("vec_data", vec_data, cur);
    chk("out_sum", out_sum, msum);
  end
  int hs_t[$];
  logic [3:0] hs_sum[$];
  always @(posedge clock) begin
    if (reset && out_valid && out_ready) begin
      hs_t.push_back(int'($time / 10));
      hs_sum.push_back(out_sum);
    end
  end
  task automatic push_seq(input logic [15:0] v[$]);
    foreach (v[i]) begin
      @(negedge clock);
      #1 in_valid = 1;
      in_data = v[i];
    end
    @(negedge clock);
    #1 in_valid = 0;
  endtask
  task automatic chk_results(string name, input logic [3:0] exp[$]);
    chk({name, " count"}, hs_sum.size(), exp.size());
    foreach (exp[i]) if (i < hs_sum.size()) chk({name, " sum"}, hs_sum[i], exp[i]);
  endtask
  initial begin
    logic [15:0] v[$];
    logic [3:0] e[$];
    logic seen;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst vec_clr", vec_clr, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst vec_data", vec_data, 16'h0);
    chk("rst out_sum", out_sum, 4'h0);
    #1 reset = 1;
    // single vector latency
    @(negedge clock);
    #1 in_valid = 1;
    in_data = 16'h9AA3;
    @(negedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    chk("t1 clear", vec_clr, 1);
    chk("t1 data", vec_data, 16'h9AA3);
    repeat (3) begin
      @(negedge clock);
      chk("t1 run", vec_clr, 0);
    end
    @(negedge clock);
    chk("t1 valid", out_valid, 1);
    chk("t1 sum", out_sum, 4'h8);
    chk("t1 clr back", vec_clr, 1);
    @(negedge clock);
    chk("t1 valid drop", out_valid, 0);
    // back-to-back
    hs_t.delete();
    hs_sum.delete();
    v = '{16'h9AA3, 16'h2BD7, 16'hEA8E};
    push_seq(v);
    repeat (20) @(negedge clock);
    e = '{4'h8, 4'hA, 4'h9};
    chk_results("b2b", e);
    if (hs_t.size() == 3) begin
      chk("b2b gap1", hs_t[1] - hs_t[0], 5);
      chk("b2b gap2", hs_t[2] - hs_t[1], 5);
    end
    // FIFO full, then backpressure in DONE
    hs_t.delete();
    hs_sum.delete();
    out_ready = 0;
    v = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F};
    foreach (v[i]) begin
      @(negedge clock);
      chk("full in_ready", in_ready, i < 5);
      #1 in_valid = 1;
      in_data = v[i];
    end
    @(negedge clock);
    #1 in_valid = 0;
    repeat (10) begin
      @(negedge clock);
      chk("bp valid", out_valid, 1);
      chk("bp sum", out_sum, 4'h1);
      chk("bp data", vec_data, 16'h0001);
      chk("bp clr", vec_clr, 1);
      chk("bp in_ready", in_ready, 0);
    end
    #1 out_ready = 1;
    repeat (30) @(negedge clock);
    e = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    chk_results("full", e);
    // reset during the second RUN cycle with two vectors queued
    v = '{16'h00FF, 16'h0FFF, 16'hFFFF};
    foreach (v[i]) begin
      @(negedge clock);
      #1 in_valid = 1;
      in_data = v[i];
    end
    @(negedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    chk("mr in run", vec_clr, 0);
    #1 reset = 0;
    #1;
    chk("mr clr", vec_clr, 1);
    chk("mr valid", out_valid, 0);
    chk("mr in_ready", in_ready, 1);
    @(negedge clock);
    #1 reset = 1;
    hs_t.delete();
    hs_sum.delete();
    repeat (20) @(negedge clock);
    chk("mr no result", hs_sum.size(), 0);
    chk("mr idle clr", vec_clr, 1);
    // simultaneous push and pop across the pointer wrap
    hs_t.delete();
    hs_sum.delete();
    out_ready = 0;
    v = '{16'h8000, 16'hC000, 16'hE000, 16'hF000};
    push_seq(v);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = out_valid;
    end
    chk("sp reached done", seen, 1);
    chk("sp in_ready before", in_ready, 1);
    #1 out_ready = 1;
    in_valid = 1;
    in_data = 16'hF800;
    @(negedge clock);
    chk("sp in_ready", in_ready, 1);
    chk("sp clear", vec_clr, 1);
    chk("sp head", vec_data, 16'hC000);
    #1 in_valid = 0;
    repeat (30) @(negedge clock);
    e = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    chk_results("sp", e);
    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      #1;
      if (!reset) reset = 1;
      else if ($urandom_range(149) == 0) reset = 0;
      in_valid = $urandom_range(1);
      in_data = 16'($urandom);
      out_ready = $urandom_range(9) < 7;
    end
    @(negedge clock);
    #1 reset = 1;
    in_valid = 0;
    out_ready = 1;
    repeat (40) @(negedge clock);
    chk("drain empty", in_ready && vec_clr && !out_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/vec_dispatch.md
Name: vec_dispatch

Overview:
Upstream feeder for the vector-sum stage. Buffers incoming DATA_W-bit vectors in a small FIFO and presents one vector at a time to the sum stage: a one-cycle active-high clear, then the vector held stable for HOLD_CYC cycles. It then captures the stage's POS_W-bit result and offers it downstream with a valid/ready handshake.

Parameters:
DATA_W, 16, vector width presented to the sum stage
POS_W, 4, width of the sum stage result
DEPTH, 4, input FIFO entries; power of two, >=2
HOLD_CYC, 3, cycles the vector is held after clear; >=1

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  DATA_W  vector to enqueue
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept; equals not-full
vec_data  output  DATA_W  vector driven to the sum stage's data input
vec_clr  output  1  active-high clear driven to the sum stage's reset input
sum_in  input  POS_W  result from the sum stage
out_sum  output  POS_W  captured result
out_valid  output  1  out_sum valid
out_ready  input  1  downstream accepts out_sum

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, FIFO empty, vec_data=0, vec_clr=1, out_sum=0, out_valid=0, in_ready=1. Reset mid-operation discards the FIFO contents, any in-flight vector, and any pending result.
- FIFO: push when in_valid&in_ready. in_ready=0 when DEPTH entries are held. No bypass: a push while full is ignored and in_data is not stored. Pop occurs only on entry to CLEAR. Simultaneous push and pop in the same cycle are both honoured, with the count unchanged. Pointers wrap modulo DEPTH.
- All outputs are registered and are Moore functions of the state.
- IDLE: vec_clr=1, vec_data holds its last value. If the FIFO is non-empty, go to CLEAR.
- CLEAR (exactly 1 cycle): vec_data=FIFO head (loaded on entry), vec_clr=1, head popped. Go to RUN with the counter at 0.
- RUN: vec_clr=0, vec_data stable. The counter increments each cycle. On the cycle the counter reaches HOLD_CYC-1, sum_in is sampled into out_sum at that clock edge and the FSM goes to DONE. The sum stage therefore sees exactly HOLD_CYC rising edges with clear low and data stable.
- DONE: out_valid=1, out_sum stable, vec_clr=1, vec_data held.
  - On out_valid&out_ready: out_valid drops next cycle.
  - If the FIFO is non-empty at that edge, go directly to CLEAR; otherwise go to IDLE.
  - While out_ready=0, stay in DONE indefinitely; the FIFO keeps accepting pushes.
- Throughput: one vector per HOLD_CYC+2 cycles with out_ready held high.
- Latency: a push into an empty FIFO in IDLE gives CLEAR on cycle +1, RUN on +2..+HOLD_CYC+1, and out_valid on +HOLD_CYC+2.
- in_data is never modified. sum_in is captured unmodified, with no width conversion.
- in_valid while in_ready=0 is a no-op, with no error flag. Upstream must hold in_valid until it sees in_ready.

Test Plan:
- Reset and single vector:
  - Stimulus: reset low 2 cycles, then push 16'h9AA3; the bench model drives sum_in=4'h8 while vec_clr=0.
  - Required: vec_clr=1 for one cycle with vec_data=16'h9AA3, then 0 for exactly 3 cycles; out_valid rises 5 cycles after the push with out_sum=4'h8; vec_clr returns to 1.
- Back-to-back vectors:
  - Stimulus: push 16'h9AA3, 16'h2BD7, 16'hEA8E on consecutive cycles, out_ready=1.
  - Required: three results in order, out_valid pulses spaced exactly 5 cycles apart, each preceded by a 1-cycle vec_clr.
- FIFO full:
  - Stimulus: hold out_ready=0 and push 6 vectors.
  - Required: 1 vector in flight and 4 queued; in_ready=0 from the 6th attempt; the 6th is dropped.
  - Then release out_ready: exactly 5 results emerge, in order.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles while in DONE.
  - Required: out_valid and out_sum stable throughout, vec_data unchanged, no new CLEAR until the handshake completes.
- Reset mid-RUN:
  - Stimulus: assert reset during the 2nd RUN cycle with 2 vectors queued.
  - Required: the same cycle shows vec_clr=1, out_valid=0, in_ready=1; after release, no result is emitted for the discarded vectors.
- Simultaneous push and pop:
  - Stimulus: FIFO holding 3 entries; push arrives on the cycle of CLEAR entry.
  - Required: count stays 3, in_ready stays 1, no entry is lost or duplicated across a pointer wrap.
